// File: rtl/dino_pkg.sv
// Shared types and default tuning constants
// for the dinosaur runner controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2,
    DEAD = 2'd3
  } game_state_t;

  localparam int GROUND_Y_DEF = 400;
  localparam int JUMP_V0_DEF  = 12;
  localparam int GRAVITY_DEF  = 1;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector with a sticky request
// that is cleared when a frame tick consumes it.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_consume,
  output logic o_req
);

  logic r_prev;
  logic r_armed;
  logic r_req;
  logic w_edge;

  // No edge until prev has seen one real sample
  assign w_edge = r_armed & i_btn & ~r_prev;
  assign o_req  = r_req | w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= 1'b1;
      if (i_consume) r_req <= 1'b0;
      else           r_req <= r_req | w_edge;
    end
  end

endmodule

// File: rtl/dino_ctrl.sv
// Game FSM, jump/duck physics, scroll enable
// and score for the dinosaur runner.
module dino_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_Y = GROUND_Y_DEF,
  parameter int JUMP_V0  = JUMP_V0_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int Y_W      = 10,
  parameter int SCORE_W  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               upbtn,
  input  logic               downbtn,
  input  logic               leftbtn,
  input  logic               rightbtn,
  input  logic               collision,
  output game_state_t        state,
  output logic [Y_W-1:0]     dino_y,
  output logic               ducking,
  output logic               scroll_en,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [Y_W-1:0] LP_GY =
    Y_W'(GROUND_Y);
  localparam logic signed [Y_W+1:0] LP_GY_S =
    (Y_W+2)'(GROUND_Y);
  localparam logic signed [Y_W:0] LP_V0 =
    (Y_W+1)'(JUMP_V0);
  localparam logic signed [Y_W:0] LP_G1 =
    (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W:0] LP_G2 =
    (Y_W+1)'(2 * GRAVITY);

  game_state_t             r_state;
  logic [Y_W-1:0]          r_y;
  logic signed [Y_W:0]     r_vel;
  logic                    r_duck;
  logic                    r_scroll;
  logic [SCORE_W-1:0]      r_score;
  logic                    r_go;

  logic                    w_req;
  logic signed [Y_W+1:0]   w_ny;
  logic signed [Y_W:0]     w_vel_nx;
  logic                    w_land;
  logic                    w_live;
  logic                    w_unused;

  btn_edge u_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (upbtn),
    .i_consume (frame_tick),
    .o_req     (w_req)
  );

  assign w_unused = leftbtn ^ rightbtn;

  assign w_ny = $signed({2'b00, r_y})
              - {r_vel[Y_W], r_vel};
  assign w_land = (w_ny >= LP_GY_S);
  assign w_vel_nx = r_vel
                  - (downbtn ? LP_G2 : LP_G1);
  assign w_live = (r_state == RUN)
               || (r_state == AIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_y      <= LP_GY;
      r_vel    <= '0;
      r_duck   <= 1'b0;
      r_scroll <= 1'b0;
      r_score  <= '0;
      r_go     <= 1'b0;
    end else if (frame_tick) begin
      if (w_live && !(&r_score))
        r_score <= r_score + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= RUN;
            r_score  <= '0;
            r_y      <= LP_GY;
            r_scroll <= 1'b1;
          end
        end
        RUN: begin
          if (collision) begin
            r_state  <= DEAD;
            r_scroll <= 1'b0;
            r_go     <= 1'b1;
          end else if (w_req) begin
            r_state <= AIR;
            r_vel   <= LP_V0;
            r_duck  <= 1'b0;
          end else begin
            r_duck <= downbtn;
          end
        end
        AIR: begin
          if (collision) begin
            r_state  <= DEAD;
            r_scroll <= 1'b0;
            r_go     <= 1'b1;
          end else begin
            r_vel <= w_vel_nx;
            if (w_land) begin
              r_y     <= LP_GY;
              r_state <= RUN;
              r_vel   <= '0;
            end else if (w_ny[Y_W+1]) begin
              r_y <= '0;
            end else begin
              r_y <= w_ny[Y_W-1:0];
            end
          end
        end
        DEAD: begin
          if (w_req) begin
            r_state <= IDLE;
            r_y     <= LP_GY;
            r_go    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign dino_y    = r_y;
  assign ducking   = r_duck;
  assign scroll_en = r_scroll;
  assign score     = r_score;
  assign game_over = r_go;

endmodule

// File: tb/tb_dino_ctrl.sv
// Vector/scoreboard bench for dino_ctrl,
// with a narrow-score instance for saturation.
module tb_dino_ctrl;
  import dino_pkg::*;

  typedef struct {
    logic up;
    logic dn;
    logic col;
    logic tk;
    int   st;
    int   y;
    logic duck;
    int   sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_tick;
  logic upbtn, downbtn;
  logic leftbtn, rightbtn;
  logic collision;

  game_state_t  state;
  logic [9:0]   dino_y;
  logic         ducking, scroll_en, game_over;
  logic [13:0]  score;

  game_state_t  s_unused_st;
  logic [9:0]   s_unused_y;
  logic         s_unused_d, s_unused_s, s_unused_g;
  logic [2:0]   sat_score;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dino_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .frame_tick(frame_tick),
    .upbtn(upbtn), .downbtn(downbtn),
    .leftbtn(leftbtn), .rightbtn(rightbtn),
    .collision(collision),
    .state(state), .dino_y(dino_y),
    .ducking(ducking), .scroll_en(scroll_en),
    .score(score), .game_over(game_over)
  );

  dino_ctrl #(.SCORE_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .frame_tick(frame_tick),
    .upbtn(upbtn), .downbtn(downbtn),
    .leftbtn(leftbtn), .rightbtn(rightbtn),
    .collision(collision),
    .state(s_unused_st), .dino_y(s_unused_y),
    .ducking(s_unused_d), .scroll_en(s_unused_s),
    .score(sat_score), .game_over(s_unused_g)
  );

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  function automatic void add(
    logic up, logic dn, logic col, logic tk,
    int st, int y, logic duck, int sc);
    vec_t v;
    v.up = up; v.dn = dn; v.col = col; v.tk = tk;
    v.st = st; v.y = y; v.duck = duck; v.sc = sc;
    vecs.push_back(v);
  endfunction

  task automatic check_vec(vec_t e, int idx);
    string p;
    p = $sformatf("step%0d", idx);
    chk({p, "_state"}, int'(state), e.st);
    chk({p, "_y"}, int'(dino_y), e.y);
    chk({p, "_duck"}, int'(ducking), int'(e.duck));
    chk({p, "_scroll"}, int'(scroll_en),
        (e.st == 1 || e.st == 2) ? 1 : 0);
    chk({p, "_over"}, int'(game_over),
        (e.st == 3) ? 1 : 0);
    chk({p, "_score"}, int'(score), e.sc);
    chk({p, "_sat"}, int'(sat_score),
        (e.sc > 7) ? 7 : e.sc);
  endtask

  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    upbtn      = v.up;
    downbtn    = v.dn;
    collision  = v.col;
    frame_tick = v.tk;
    sb.push_back(v);
    @(negedge clk);
    frame_tick = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got 0 expected 1");
    end else begin
      e = sb.pop_front();
      check_vec(e, idx);
    end
  endtask

  task automatic check_reset(string p);
    chk({p, "_state"}, int'(state), 0);
    chk({p, "_y"}, int'(dino_y), 400);
    chk({p, "_duck"}, int'(ducking), 0);
    chk({p, "_scroll"}, int'(scroll_en), 0);
    chk({p, "_score"}, int'(score), 0);
    chk({p, "_over"}, int'(game_over), 0);
    chk({p, "_sat"}, int'(sat_score), 0);
  endtask

  initial begin
    int sc, y, v, k;
    logic d;
    int st;

    rst_n = 1'b0;
    upbtn = 1'b1;
    downbtn = 1'b0;
    leftbtn = 1'b0;
    rightbtn = 1'b0;
    collision = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // upbtn held through reset must not start a game
    rst_n = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    leftbtn = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    leftbtn = 1'b0;
    chk("held_thru_reset", int'(state), 0);

    sc = 0;
    add(0, 0, 0, 0, 0, 400, 0, 0);
    add(1, 0, 0, 0, 0, 400, 0, 0);
    add(0, 0, 0, 1, 1, 400, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 0, 1, 1, 400, 0, i);
    sc = 5;

    // full jump, upbtn held for the first ticks
    sc++;
    add(1, 0, 0, 1, 2, 400, 0, sc);
    y = 400; v = 12; st = 2;
    for (int i = 1; i <= 25; i++) begin
      if (y - v >= 400) begin
        y = 400; st = 1; v = 0;
      end else begin
        y = y - v; v = v - 1;
      end
      sc++;
      add((i <= 3), 0, 0, 1, st, y, 0, sc);
    end
    sc++; add(0, 1, 0, 1, 1, 400, 1, sc);
    sc++; add(0, 0, 0, 1, 1, 400, 0, sc);

    // fast fall from tick 3
    sc++;
    add(1, 0, 0, 1, 2, 400, 0, sc);
    y = 400; v = 12; st = 2; k = 0;
    while (st == 2 && k < 40) begin
      k++;
      d = (k >= 3);
      if (y - v >= 400) begin
        y = 400; st = 1; v = 0;
      end else begin
        y = y - v; v = v - (d ? 2 : 1);
      end
      sc++;
      add(0, d, 0, 1, st, y, 0, sc);
    end
    sc++; add(0, 1, 0, 1, 1, 400, 1, sc);
    sc++; add(0, 0, 0, 1, 1, 400, 0, sc);

    // collision beats a jump edge in AIR
    sc++;
    add(1, 0, 0, 1, 2, 400, 0, sc);
    y = 400; v = 12;
    for (int i = 1; i <= 2; i++) begin
      y = y - v; v = v - 1; sc++;
      add(0, 0, 0, 1, 2, y, 0, sc);
    end
    add(0, 1, 1, 0, 2, y, 0, sc);
    sc++;
    add(1, 0, 1, 1, 3, y, 0, sc);
    add(1, 0, 0, 1, 3, y, 0, sc);
    add(0, 0, 0, 1, 3, y, 0, sc);

    // restart: held button stays in IDLE
    add(1, 0, 0, 1, 0, 400, 0, sc);
    add(1, 0, 0, 1, 0, 400, 0, sc);
    add(1, 0, 0, 1, 0, 400, 0, sc);
    add(0, 0, 0, 0, 0, 400, 0, sc);
    sc = 0;
    add(1, 0, 0, 1, 1, 400, 0, 0);

    // collision in RUN
    sc++; add(0, 1, 0, 1, 1, 400, 1, sc);
    sc++; add(0, 0, 0, 1, 1, 400, 0, sc);
    sc++; add(0, 1, 1, 1, 3, 400, 0, sc);
    add(0, 0, 0, 1, 3, 400, 0, sc);
    add(1, 0, 0, 1, 0, 400, 0, sc);
    add(0, 0, 0, 0, 0, 400, 0, sc);
    sc = 0;
    add(1, 0, 0, 1, 1, 400, 0, 0);
    add(0, 0, 0, 0, 1, 400, 0, 0);

    // jump then six airborne ticks before reset
    sc++;
    add(1, 0, 0, 1, 2, 400, 0, sc);
    y = 400; v = 12;
    for (int i = 1; i <= 6; i++) begin
      y = y - v; v = v - 1; sc++;
      add(0, 0, 0, 1, 2, y, 0, sc);
    end

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dino_ctrl.md
# dino_ctrl

Game-sequencing controller for the dinosaur runner. Sits between the PS/2 keyboard decoder's 4-bit button vector and the VGA renderer/scroller. Owns the game state machine, the jump/duck physics of the player sprite, the scroll enable, and the score counter. All state advances once per video frame on `frame_tick`.

## Interface

Parameters:
- `GROUND_Y`, default 400: sprite top Y on the ground, in screen pixels, where down is positive.
- `JUMP_V0`, default 12: initial upward velocity, in px/frame.
- `GRAVITY`, default 1: velocity decrement per frame.
- `Y_W`, default 10: width of `dino_y`.
- `SCORE_W`, default 14: width of `score`.

Ports:
- `clk` in 1: system clock, the same clock as the keyboard and VGA logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per VGA frame, sourced from vsync timing.
- `upbtn`, `downbtn`, `leftbtn`, `rightbtn` in 1 each: level inputs from `BUTTON[3]`, `[2]`, `[0]` and `[1]`, synchronous to `clk`.
- `collision` in 1: level from the renderer, sampled only on `frame_tick`.
- `state` out 2: 0 = IDLE, 1 = RUN, 2 = AIR, 3 = DEAD.
- `dino_y` out `Y_W`: sprite top Y.
- `ducking` out 1: selects the duck sprite.
- `scroll_en` out 1: obstacle and ground scroll enable.
- `score` out `SCORE_W`: frames survived, saturating.
- `game_over` out 1: high while in DEAD.

## Operation

**Jump request capture**
- A rising edge of `upbtn` (relative to the previous cycle) sets `jump_req`.
- `jump_req` is cleared when a `frame_tick` consumes it.
- An edge in the same cycle as `frame_tick` is consumed by that tick.
- `leftbtn` and `rightbtn` are reserved and ignored.

**Frame update.** On each `frame_tick` cycle, evaluate in priority order:
- **IDLE:** if `jump_req`, go to RUN, clear `score`, and set `dino_y` to `GROUND_Y`.
- **RUN:**
  - If `collision`, go to DEAD.
  - Else if `jump_req`, go to AIR, load `vel` with `JUMP_V0`, and force `ducking` to 0.
  - Else set `ducking` to `downbtn`.
- **AIR:**
  - If `collision`, go to DEAD and freeze `dino_y`.
  - Else compute `ny = dino_y - vel`.
  - If `ny >= GROUND_Y`: set `dino_y` to `GROUND_Y`, go to RUN, and set `vel` to 0.
  - Else if `ny < 0`: set `dino_y` to 0.
  - Else set `dino_y` to `ny`.
  - `vel` then becomes `vel - GRAVITY`, or `vel - 2*GRAVITY` while `downbtn` is held (fast fall).
  - `ducking` stays 0 in AIR.
- **DEAD:** if `jump_req`, go to IDLE and set `dino_y` to `GROUND_Y`. Otherwise hold.

**Other rules**
- `score` increments by 1 on every `frame_tick` in RUN or AIR and saturates at all-ones. It is held in DEAD and IDLE.
- `scroll_en` is 1 exactly in RUN and AIR. `game_over` is 1 exactly in DEAD.
- Arithmetic: `vel` is signed, `Y_W+1` bits. `ny` is computed signed in `Y_W+2` bits before the compare and clamp.
- `collision` has priority over landing and over a jump request in the same tick.

## Timing

- All outputs are registered. They change on the `clk` edge that ends the `frame_tick` cycle (one-cycle latency) and are otherwise stable for the whole frame.
- Reset values:
  - `state` = IDLE, `dino_y` = `GROUND_Y`, `ducking` = 0, `scroll_en` = 0, `score` = 0, `game_over` = 0.
  - Internal state: `vel` = 0, `jump_req` = 0, previous-`upbtn` register = 0.
- An `upbtn` held high through reset does not generate an edge. The previous-`upbtn` register is loaded from `upbtn` on the first cycle after reset; it does not stay at 0.
- Reset asserted mid-jump returns immediately, asynchronously, to IDLE on the ground.
- With default parameters a jump rises 12 frames to apex Y = 322, holds 1 frame, and lands on frame 25 at Y = 400.
- Holding `upbtn` never repeats a jump; each jump needs a release and a new press.
- With `frame_tick` low, nothing except `jump_req` capture changes.

## Structure

- Package `dino_pkg` holds:
  - the `game_state_t` enum (IDLE/RUN/AIR/DEAD, 2-bit encoding as listed above);
  - default constants for `GROUND_Y`, `JUMP_V0` and `GRAVITY`.
- Sub-module `btn_edge` handles per-button edge detection and sticky request with clear-on-consume. It is instantiated for `upbtn` only.
- The FSM, physics and score stay in `dino_ctrl`.
- Integration: instantiated inside the game top between the Keyboard outputs and the renderer. `frame_tick` comes from the VGA timing generator.

## Test plan

- **Reset then start:** reset, then pulse `upbtn`, then one `frame_tick`. Expect `state` = RUN, `scroll_en` = 1, `score` = 0. After 5 more ticks, `score` = 5.
- **Full jump (defaults):** from RUN, press `upbtn` and tick. Expect `dino_y` sequence 388, 377, … reaching 322 at tick 12, 322 again at tick 13, then 400 with `state` = RUN at tick 25.
- **Fast fall:** jump, then hold `downbtn` from tick 3 onward. Landing occurs before tick 25 with `dino_y` exactly 400 (clamped, never greater than 400). `ducking` stays 0 in AIR and equals `downbtn` once in RUN.
- **Collision priority:** in the same tick, assert `collision` and a new `upbtn` edge while in AIR. Expect `state` = DEAD, `dino_y` frozen, `scroll_en` = 0, `game_over` = 1, `score` held.
- **Restart from DEAD:** press `upbtn` and tick. Expect `state` = IDLE and `dino_y` = 400. Holding `upbtn` through further ticks does not leave IDLE; a fresh press then starts RUN with `score` = 0.
- **Asynchronous reset mid-jump:** drive `rst_n` low between clock edges at tick 6 of a jump. Outputs return to reset values immediately. `score` saturation is checked separately with `SCORE_W` = 3: it holds at 7.
